entity_collision_scheduler: RTL and testbench
=============================================

# entity_collision_scheduler

Time-multiplexed collision prober for up to N_ENT game entities (player, slimes, projectiles) against the single shared level lookup port. On each simulation tick it snapshots every entity position, walks four edge probes per entity through the level query port in a fixed order, and publishes per-entity hit flags atomically. It is the multi-entity, parametrised successor to the single-player collision resolver and sits between the entity state registers and the level block's second read port.

## Interface

Parameters:
- N_ENT, 4: number of entity channels (1..16)
- COORD_W, 10: coordinate width, matches VGA counters
- BLK_W, 3: level block-type width
- ENT_W, 16: entity bounding-box width in pixels (even, ≥2)
- ENT_H, 16: entity bounding-box height in pixels (even, ≥2)
- SOLID_MASK, 8'hFE: bit k set means block type k is solid (type 0 = air)
- LVL_LAT, 0: level read latency in cycles, 0 (combinational) or 1 (registered)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle pulse starting a sweep
- ent_pos  in  N_ENT*2*COORD_W  entity i at [i*2*COORD_W +: 2*COORD_W], x in low half, y in high half (top-left corner)
- ent_valid  in  N_ENT  entity enable mask
- lvl_x, lvl_y  out  COORD_W each  level query address
- lvl_data  in  BLK_W  block type at (lvl_x, lvl_y), LVL_LAT cycles later
- col_flags  out  N_ENT*4  entity i at [4i +: 4]: bit0 down, bit1 up, bit2 left, bit3 right
- col_valid  out  1  one-cycle pulse: col_flags just updated
- busy  out  1  sweep in progress
- overrun  out  1  sticky: tick arrived while busy

## Operation

- States: IDLE, PROBE, DRAIN (only when LVL_LAT=1).
- IDLE: tick=1 → snapshot ent_pos and ent_valid into internal registers, probe index p=0, go PROBE.
- PROBE: drive probe p (entity p/4, kind p%4) on lvl_x/lvl_y; p increments each cycle; after p=4*N_ENT-1 go DRAIN (LVL_LAT=1) or IDLE (LVL_LAT=0).
- DRAIN: one cycle to capture the last read, then IDLE.
- Probe order: entity 0..N_ENT-1; per entity down, up, left, right.
- Probe points from snapshot (x,y): down (x+ENT_W/2, y+ENT_H); up (x+ENT_W/2, y-1); left (x-1, y+ENT_H/2); right (x+ENT_W, y+ENT_H/2).
- Arithmetic in COORD_W+1 bits; result outside 0..2^COORD_W-1 → hit forced 1 (world edge solid), lvl_x/lvl_y drive the truncated value, lvl_data ignored.
- Hit = SOLID_MASK[lvl_data] captured LVL_LAT cycles after issue, into a shadow flag register.
- Disabled entities (snapshot ent_valid bit 0) are still probed (fixed timing); their flags forced 0.
- Sweep end: shadow copied to col_flags in one cycle; col_valid pulses. col_flags stable otherwise.
- lvl_x/lvl_y = 0 whenever not in PROBE.
- tick while busy: ignored, overrun ← 1; cleared only by reset.
- Simultaneous tick and reset: reset wins.

## Timing

- Reset (async): state IDLE, col_flags=0, col_valid=0, busy=0, overrun=0, lvl_x=lvl_y=0, shadow cleared.
- tick sampled high at edge T: probes issued in cycles T+1..T+4N_ENT.
- busy high cycles T+1..T+4N_ENT+LVL_LAT.
- col_flags update and col_valid high in cycle T+4N_ENT+LVL_LAT+1; busy low that cycle; a tick in that cycle is accepted.
- Sweep throughput: one probe per cycle regardless of LVL_LAT (pipelined capture).
- Reset mid-sweep: sweep aborted, no col_valid, all outputs to reset values.
- ent_pos changes after T do not affect the sweep in flight.

## Test plan

- Reset with ent_pos nonzero, tick held low → all outputs 0; lvl_x=lvl_y=0 for 20 cycles.
- N_ENT=2, ENT_W=ENT_H=16, LVL_LAT=0, level model solid (type 1) for y≥400 else 0; entity0 (100,384), entity1 (200,100), ent_valid=2'b11, tick at T → lvl addresses (108,400),(108,383),(99,392),(116,392),(208,116),… in T+1..T+8; col_valid at T+9; col_flags=8'b0000_0001.
- Entity0 at (0,100), level all air → left probe underflows → entity0 flags 4'b0100; lvl_x=1023 during that probe.
- Same as scenario 2 with ent_valid=2'b10 → col_flags=8'b0000_0000; timing unchanged (col_valid at T+9).
- tick again at T+3 → ignored, overrun=1 and stays 1, exactly one col_valid at T+9; tick at T+9 accepted, second col_valid at T+18.
- LVL_LAT=1 with registered level model → col_valid at T+10, same flags as scenario 2; reset pulsed at T+4 in a repeat run → no col_valid, col_flags=0, busy=0.

Source files
------------

// File: rtl/entity_collision_scheduler.sv
// entity_collision_scheduler: time-multiplexed four-edge collision prober for N_ENT entities on one level read port.
// Flags are built in a shadow register and published atomically at the end of each sweep.
module entity_collision_scheduler #(
  parameter int N_ENT = 4,
  parameter int COORD_W = 10,
  parameter int BLK_W = 3,
  parameter int ENT_W = 16,
  parameter int ENT_H = 16,
  parameter logic [(1<<BLK_W)-1:0] SOLID_MASK = 8'hFE,
  parameter int LVL_LAT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [N_ENT*2*COORD_W-1:0]   ent_pos,
  input  logic [N_ENT-1:0]             ent_valid,
  output logic [COORD_W-1:0]           lvl_x,
  output logic [COORD_W-1:0]           lvl_y,
  input  logic [BLK_W-1:0]             lvl_data,
  output logic [N_ENT*4-1:0]           col_flags,
  output logic                         col_valid,
  output logic                         busy,
  output logic                         overrun
);
  localparam int EW = N_ENT > 1 ? $clog2(N_ENT) : 1;
  localparam int PW = EW + 2;
  localparam int CW = COORD_W + 1;
  localparam logic [PW-1:0] LAST = PW'(4*N_ENT-1);
  localparam logic [CW-1:0] HW = CW'(ENT_W/2);
  localparam logic [CW-1:0] FW = CW'(ENT_W);
  localparam logic [CW-1:0] HH = CW'(ENT_H/2);
  localparam logic [CW-1:0] FH = CW'(ENT_H);
  localparam logic [CW-1:0] M1 = '1;

  typedef enum logic [1:0] {IDLE, PROBE, DRAIN} state_t;

  state_t                     r_state;
  logic [PW-1:0]              r_p;
  logic [N_ENT*2*COORD_W-1:0] r_pos;
  logic [N_ENT-1:0]           r_valid;
  logic [N_ENT*4-1:0]         r_shadow;

  logic [EW-1:0]      w_ent;
  logic [1:0]         w_kind;
  logic [COORD_W-1:0] w_x, w_y;
  logic [CW-1:0]      w_px, w_py;
  logic               w_probe, w_oob, w_hit;
  logic               w_cap_en, w_cap_oob;
  logic [PW-1:0]      w_cap_idx;
  logic [N_ENT*4-1:0] w_shadow, w_mask;

  assign w_ent   = r_p[PW-1:2];
  assign w_kind  = r_p[1:0];
  assign w_x     = r_pos[w_ent*2*COORD_W +: COORD_W];
  assign w_y     = r_pos[w_ent*2*COORD_W + COORD_W +: COORD_W];
  // One extra bit catches both underflow (-1) and overflow past the world edge
  assign w_px    = {1'b0, w_x} + (w_kind == 2'd2 ? M1 : w_kind == 2'd3 ? FW : HW);
  assign w_py    = {1'b0, w_y} + (w_kind == 2'd0 ? FH : w_kind == 2'd1 ? M1 : HH);
  assign w_probe = r_state == PROBE;
  assign w_oob   = w_px[COORD_W] | w_py[COORD_W];
  assign lvl_x   = w_probe ? w_px[COORD_W-1:0] : '0;
  assign lvl_y   = w_probe ? w_py[COORD_W-1:0] : '0;
  assign busy    = r_state != IDLE;

  generate
    if (LVL_LAT == 0) begin : g_comb
      assign w_cap_en  = w_probe;
      assign w_cap_idx = r_p;
      assign w_cap_oob = w_oob;
    end else begin : g_reg
      logic          r_en, r_oob;
      logic [PW-1:0] r_idx;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_en  <= 1'b0;
          r_oob <= 1'b0;
          r_idx <= '0;
        end else begin
          r_en  <= w_probe;
          r_oob <= w_oob;
          r_idx <= r_p;
        end
      assign w_cap_en  = r_en;
      assign w_cap_idx = r_idx;
      assign w_cap_oob = r_oob;
    end
  endgenerate

  for (genvar i = 0; i < N_ENT; i++) begin : g_mask
    assign w_mask[4*i +: 4] = {4{r_valid[i]}};
  end

  assign w_hit = w_cap_oob | SOLID_MASK[lvl_data];

  always_comb begin
    w_shadow = r_shadow;
    if (w_cap_en) w_shadow[w_cap_idx] = w_hit;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_pos     <= '0;
      r_valid   <= '0;
      r_shadow  <= '0;
      col_flags <= '0;
      col_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      col_valid <= 1'b0;
      r_shadow  <= w_shadow;
      if (tick && r_state != IDLE) overrun <= 1'b1;
      if (w_cap_en && w_cap_idx == LAST) begin
        col_flags <= w_shadow & w_mask;
        col_valid <= 1'b1;
      end
      if (r_state == IDLE && tick) begin
        r_state <= PROBE;
        r_p     <= '0;
        r_pos   <= ent_pos;
        r_valid <= ent_valid;
      end else if (w_probe) begin
        r_p <= r_p + 1'b1;
        if (r_p == LAST) r_state <= LVL_LAT != 0 ? DRAIN : IDLE;
      end else if (r_state == DRAIN) begin
        r_state <= IDLE;
      end
    end
endmodule

// File: tb/tb_entity_collision_scheduler.sv
// tb_entity_collision_scheduler: scoreboard bench for two instances (combinational and registered level port).
module tb_entity_collision_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst = 2'b11;
  logic [1:0]  tick = 2'b00;
  logic [39:0] ent_pos;
  logic [1:0]  ent_valid;
  logic [9:0]  lx0, ly0, lx1, ly1;
  logic [2:0]  ld0, ld1;
  logic [7:0]  cf0, cf1;
  logic        cv0, cv1, b0, b1, o0, o1;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {logic [7:0] f; int c;} exp_t;
  exp_t q0[$], q1[$];

  entity_collision_scheduler #(.N_ENT(2), .LVL_LAT(0)) dut0 (
    .clk(clk), .reset(rst[0]), .tick(tick[0]), .ent_pos(ent_pos), .ent_valid(ent_valid),
    .lvl_x(lx0), .lvl_y(ly0), .lvl_data(ld0), .col_flags(cf0), .col_valid(cv0),
    .busy(b0), .overrun(o0));

  entity_collision_scheduler #(.N_ENT(2), .LVL_LAT(1)) dut1 (
    .clk(clk), .reset(rst[1]), .tick(tick[1]), .ent_pos(ent_pos), .ent_valid(ent_valid),
    .lvl_x(lx1), .lvl_y(ly1), .lvl_data(ld1), .col_flags(cf1), .col_valid(cv1),
    .busy(b1), .overrun(o1));

  always @(posedge clk) cyc <= cyc + 1;
  // Level: type 1 (solid) for y >= 400, air elsewhere
  assign ld0 = ly0 >= 10'd400 ? 3'd1 : 3'd0;
  always @(posedge clk) ld1 <= ly1 >= 10'd400 ? 3'd1 : 3'd0;

  function automatic logic [39:0] pos(input int x0, y0, x1, y1);
    return {10'(y1), 10'(x1), 10'(y0), 10'(x0)};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic sb_pop(input int d, input logic [7:0] f);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d col_valid: pulse at cycle %0d, expected no pulse", d, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("dut%0d col_flags", d), 32'(f), 32'(e.f));
      chk($sformatf("dut%0d col_valid cycle", d), cyc, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (cv0) sb_pop(0, cf0);
    if (cv1) sb_pop(1, cf1);
  end

  task automatic do_tick(input int d, input bit push, input logic [7:0] f, output int e);
    e = cyc + 1;
    tick[d] = 1'b1;
    if (push && d == 0) q0.push_back('{f: f, c: e + 8});
    if (push && d == 1) q1.push_back('{f: f, c: e + 9});
    @(negedge clk);
    tick[d] = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int ex[8] = '{108, 108, 99, 116, 208, 208, 199, 216};
  int ey[8] = '{400, 383, 392, 392, 116, 99, 108, 108};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, e2;
    ent_pos = pos(100, 384, 200, 100);
    ent_valid = 2'b11;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    for (int i = 0; i < 20; i++) begin
      chk("reset idle dut0", {lx0, ly0, cf0, cv0, b0, o0}, 32'h0);
      chk("reset idle dut1", {lx1, ly1, cf1, cv1, b1, o1}, 32'h0);
      @(negedge clk);
    end
    do_tick(0, 1, 8'h01, e);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("probe %0d addr", k), {12'h0, lx0, ly0}, 32'((ex[k] << 10) | ey[k]));
      chk($sformatf("probe %0d busy", k), 32'(b0), 32'h1);
      @(negedge clk);
    end
    chk("busy after sweep", 32'(b0), 32'h0);
    chk("lvl addr after sweep", {12'h0, lx0, ly0}, 32'h0);
    repeat (3) @(negedge clk);
    ent_valid = 2'b10;
    do_tick(0, 1, 8'h00, e);
    wait_until(e + 10);
    ent_valid = 2'b11;
    ent_pos = pos(0, 100, 200, 100);
    do_tick(0, 1, 8'h04, e);
    repeat (2) @(negedge clk);
    chk("left underflow lvl_x", 32'(lx0), 32'd1023);
    chk("left underflow lvl_y", 32'(ly0), 32'd108);
    wait_until(e + 10);
    ent_pos = pos(1015, 1015, 300, 395);
    do_tick(0, 1, 8'hDF, e);
    wait_until(e + 10);
    chk("overrun before", 32'(o0), 32'h0);
    ent_pos = pos(100, 384, 200, 100);
    do_tick(0, 1, 8'h01, e);
    ent_pos = pos(1015, 1015, 300, 395);
    wait_until(e + 2);
    do_tick(0, 0, 8'h00, e2);
    chk("overrun set", 32'(o0), 32'h1);
    wait_until(e + 8);
    do_tick(0, 1, 8'hDF, e2);
    wait_until(e2 + 10);
    chk("overrun sticky", 32'(o0), 32'h1);
    chk("overrun dut1 clear", 32'(o1), 32'h0);
    ent_pos = pos(100, 384, 200, 100);
    do_tick(1, 1, 8'h01, e);
    wait_until(e + 11);
    do_tick(1, 0, 8'h00, e);
    wait_until(e + 3);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort col_flags", 32'(cf1), 32'h0);
    chk("abort busy", 32'(b1), 32'h0);
    chk("abort lvl addr", {12'h0, lx1, ly1}, 32'h0);
    chk("dut0 pending", q0.size(), 32'h0);
    chk("dut1 pending", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
